// File: rtl/pid_pkg.sv
// Shared widths and FSM encoding for the rpm_pid_controller speed loop.
package pid_pkg;

    localparam int ERR_W     = 11;
    localparam int INTEG_W   = 18;
    localparam int ACC_W     = 36;
    localparam int DUTY_W    = 8;
    localparam int GAIN_FRAC = 8;
    localparam int GAIN_W    = 16;
    localparam int PROD_W    = GAIN_W + 1 + INTEG_W;

    typedef enum logic [2:0] {
        IDLE,
        ERROR,
        MUL_P,
        MUL_I,
        MUL_D,
        SUM,
        OUT
    } pid_state_t;

endpackage

// File: rtl/sample_timer.sv
// Control-period counter: emits a registered one-cycle tick every SAMPLE_CYCLES clocks;
// a synchronous clear holds the count at zero.
module sample_timer #(
    parameter int SAMPLE_CYCLES = 1250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(SAMPLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/rpm_pid_controller.sv
// Fixed-point PI(D) speed loop producing a saturated 8-bit PWM duty from target/actual RPM.
// Define PID_DERIVATIVE_EN to build the derivative term (MUL_D state, e_prev, KD path).
module rpm_pid_controller
    import pid_pkg::*;
#(
    parameter int          SAMPLE_CYCLES = 1250000,
    parameter logic [15:0] KP            = 16'd256,
    parameter logic [15:0] KI            = 16'd32,
    parameter logic [15:0] KD            = 16'd0,
    parameter int          INTEG_LIMIT   = 100000
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic              enable_in,
    input  logic [9:0]        target_rpm_in,
    input  logic [9:0]        actual_rpm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_valid_out,
    output logic              saturated_out
);

    localparam logic signed [INTEG_W:0] I_MAX = (INTEG_W + 1)'(INTEG_LIMIT);
    localparam logic signed [INTEG_W:0] I_MIN = -I_MAX;

    pid_state_t                 state;
    logic                       tick;
    logic signed [ERR_W-1:0]    err_now;
    logic signed [ERR_W-1:0]    err_p0;
    logic signed [INTEG_W-1:0]  integ;
    logic signed [INTEG_W:0]    integ_sum;
    logic                       windup_hold;
    logic signed [GAIN_W:0]     mul_a;
    logic signed [INTEG_W-1:0]  mul_b;
    logic signed [PROD_W-1:0]   product;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_p1;
    logic [DUTY_W-1:0]          duty_p2;
    logic                       sat_hi_p2, sat_lo_p2;
    logic                       sat_hi, sat_lo;
`ifdef PID_DERIVATIVE_EN
    logic signed [ERR_W-1:0]    err_prev;
    logic signed [ERR_W:0]      err_diff;
`endif

    function automatic logic signed [INTEG_W-1:0] clamp_integ(input logic signed [INTEG_W:0] sum);
        if (sum > I_MAX) return I_MAX[INTEG_W-1:0];
        if (sum < I_MIN) return I_MIN[INTEG_W-1:0];
        return sum[INTEG_W-1:0];
    endfunction

    // Returns {clip_high, clip_low, duty} for the Q8 accumulator.
    function automatic logic [DUTY_W+1:0] saturate_duty(input logic signed [ACC_W-1:0] acc_in);
        logic signed [ACC_W-1:0] u;
        u = acc_in >>> GAIN_FRAC;
        if (u[ACC_W-1]) return {2'b01, {DUTY_W{1'b0}}};
        if (|u[ACC_W-2:DUTY_W]) return {2'b10, {DUTY_W{1'b1}}};
        return {2'b00, u[DUTY_W-1:0]};
    endfunction

    sample_timer #(.SAMPLE_CYCLES(SAMPLE_CYCLES)) u_timer (
        .clk   (clk_in),
        .rst_n (reset_n_in),
        .clear (!enable_in),
        .tick  (tick)
    );

    assign err_now     = $signed({1'b0, target_rpm_in}) - $signed({1'b0, actual_rpm_in});
    assign integ_sum   = {integ[INTEG_W-1], integ} + {{(INTEG_W + 1 - ERR_W){err_now[ERR_W-1]}}, err_now};
    assign windup_hold = (sat_hi && !err_now[ERR_W-1] && (err_now != '0)) || (sat_lo && err_now[ERR_W-1]);
`ifdef PID_DERIVATIVE_EN
    assign err_diff    = {err_p0[ERR_W-1], err_p0} - {err_prev[ERR_W-1], err_prev};
`endif

    // Single shared multiplier, operands steered by the current state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            MUL_P: begin
                mul_a = {1'b0, KP};
                mul_b = {{(INTEG_W - ERR_W){err_p0[ERR_W-1]}}, err_p0};
            end
            MUL_I: begin
                mul_a = {1'b0, KI};
                mul_b = integ;
            end
            MUL_D: begin
                mul_a = {1'b0, KD};
`ifdef PID_DERIVATIVE_EN
                mul_b = {{(INTEG_W - ERR_W - 1){err_diff[ERR_W]}}, err_diff};
`endif
            end
            default: ;
        endcase
    end

    assign product  = PROD_W'(mul_a) * PROD_W'(mul_b);
    assign prod_ext = ACC_W'(product);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state          <= IDLE;
            err_p0         <= '0;
            integ          <= '0;
            acc_p1         <= '0;
            duty_p2        <= '0;
            sat_hi_p2      <= 1'b0;
            sat_lo_p2      <= 1'b0;
            sat_hi         <= 1'b0;
            sat_lo         <= 1'b0;
            duty_out       <= '0;
            duty_valid_out <= 1'b0;
            saturated_out  <= 1'b0;
`ifdef PID_DERIVATIVE_EN
            err_prev       <= '0;
`endif
        end else if (!enable_in) begin
            state          <= IDLE;
            err_p0         <= '0;
            integ          <= '0;
            acc_p1         <= '0;
            duty_p2        <= '0;
            sat_hi_p2      <= 1'b0;
            sat_lo_p2      <= 1'b0;
            sat_hi         <= 1'b0;
            sat_lo         <= 1'b0;
            duty_out       <= '0;
            duty_valid_out <= 1'b0;
            saturated_out  <= 1'b0;
`ifdef PID_DERIVATIVE_EN
            err_prev       <= '0;
`endif
        end else begin
            duty_valid_out <= 1'b0;
            case (state)
                IDLE: if (tick) state <= ERROR;
                // Error stage: sample inputs, update integrator unless winding further into a clip
                ERROR: begin
                    err_p0 <= err_now;
                    if (!windup_hold) integ <= clamp_integ(integ_sum);
                    state  <= MUL_P;
                end
                MUL_P: begin
                    acc_p1 <= prod_ext;
                    state  <= MUL_I;
                end
                MUL_I: begin
                    acc_p1 <= acc_p1 + prod_ext;
`ifdef PID_DERIVATIVE_EN
                    state  <= MUL_D;
`else
                    state  <= SUM;
`endif
                end
`ifdef PID_DERIVATIVE_EN
                MUL_D: begin
                    acc_p1 <= acc_p1 + prod_ext;
                    state  <= SUM;
                end
`endif
                // Sum stage: scale back from Q8 and clip into the duty range
                SUM: begin
                    {sat_hi_p2, sat_lo_p2, duty_p2} <= saturate_duty(acc_p1);
`ifdef PID_DERIVATIVE_EN
                    err_prev <= err_p0;
`endif
                    state <= OUT;
                end
                OUT: begin
                    duty_out       <= duty_p2;
                    sat_hi         <= sat_hi_p2;
                    sat_lo         <= sat_lo_p2;
                    saturated_out  <= sat_hi_p2 | sat_lo_p2;
                    duty_valid_out <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpm_pid_controller.sv
// Scoreboard bench for rpm_pid_controller: several gain sets run in lockstep against
// an arithmetic reference model of the control law.
module tb_rpm_pid_controller;

    localparam int N  = 20;
    localparam int NI = 5;
`ifdef PID_DERIVATIVE_EN
    localparam int LAT  = 7;
    localparam bit D_ON = 1'b1;
`else
    localparam int LAT  = 6;
    localparam bit D_ON = 1'b0;
`endif

    localparam logic [15:0] KP_T [NI] = '{16'd256, 16'd0,   16'd0,   16'd0,   16'd200};
    localparam logic [15:0] KI_T [NI] = '{16'd0,   16'd128, 16'd256, 16'd0,   16'd24};
    localparam logic [15:0] KD_T [NI] = '{16'd0,   16'd0,   16'd0,   16'd256, 16'd100};
    localparam int          LIM_T[NI] = '{100000,  100000,  100000,  100000,  3000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [9:0] tgt = '0;
    logic [9:0] act = '0;
    logic [7:0] duty [NI];
    logic       vld  [NI];
    logic       sat  [NI];

    always #4 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            rpm_pid_controller #(
                .SAMPLE_CYCLES (N),
                .KP            (KP_T[g]),
                .KI            (KI_T[g]),
                .KD            (KD_T[g]),
                .INTEG_LIMIT   (LIM_T[g])
            ) u_dut (
                .clk_in         (clk),
                .reset_n_in     (rst_n),
                .enable_in      (en),
                .target_rpm_in  (tgt),
                .actual_rpm_in  (act),
                .duty_out       (duty[g]),
                .duty_valid_out (vld[g]),
                .saturated_out  (sat[g])
            );
        end
    endgenerate

    int     errors = 0;
    int     checks = 0;
    int     exp_q [NI][$];
    longint m_i  [NI];
    int     m_ep [NI];
    bit     m_hi [NI];
    bit     m_lo [NI];

    function automatic void check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NI; k++) begin
            m_i[k]  = 0;
            m_ep[k] = 0;
            m_hi[k] = 1'b0;
            m_lo[k] = 1'b0;
            exp_q[k].delete();
        end
    endfunction

    // Control law as plain integer arithmetic; result queued as sat*256 + duty.
    function automatic void model_step(int t, int a);
        for (int k = 0; k < NI; k++) begin
            int     e;
            int     dv;
            longint s;
            longint acc;
            longint u;
            e = t - a;
            if (!((m_hi[k] && e > 0) || (m_lo[k] && e < 0))) begin
                s = m_i[k] + e;
                if (s > LIM_T[k]) s = LIM_T[k];
                if (s < -LIM_T[k]) s = -LIM_T[k];
                m_i[k] = s;
            end
            acc = longint'(KP_T[k]) * longint'(e) + longint'(KI_T[k]) * m_i[k];
            if (D_ON) acc = acc + longint'(KD_T[k]) * longint'(e - m_ep[k]);
            u = acc >>> 8;
            m_hi[k] = (u > 255);
            m_lo[k] = (u < 0);
            dv = m_hi[k] ? 255 : (m_lo[k] ? 0 : int'(u));
            m_ep[k] = e;
            exp_q[k].push_back(((m_hi[k] || m_lo[k]) ? 256 : 0) + dv);
        end
    endfunction

    always @(posedge clk) begin : monitor
        int x;
        #1;
        for (int k = 0; k < NI; k++) begin
            if (rst_n && vld[k]) begin
                if (exp_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid[%0d]: got valid with duty %0d, expected no update", k, duty[k]);
                end else begin
                    x = exp_q[k].pop_front();
                    check($sformatf("duty[%0d]", k), int'(duty[k]), x % 256);
                    check($sformatf("saturated[%0d]", k), int'(sat[k]), x / 256);
                end
            end
        end
    end

    task automatic wait_valid(int want);
        int c;
        bit seen;
        c = 0;
        seen = 1'b0;
        while (c < 3 * N && !seen) begin
            @(posedge clk);
            #1;
            c++;
            if (vld[0]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL latency: got no valid within %0d cycles, expected one after %0d", 3 * N, want);
        end else begin
            check("latency", c, want);
        end
    endtask

    task automatic do_update(int t, int a, bit first);
        tgt = 10'(t);
        act = 10'(a);
        model_step(t, a);
        if (first) en = 1'b1;
        wait_valid(first ? N + LAT : N);
    endtask

    task automatic check_idle(string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_duty[%0d]", tag, k), int'(duty[k]), 0);
            check($sformatf("%s_sat[%0d]", tag, k), int'(sat[k]), 0);
            check($sformatf("%s_valid[%0d]", tag, k), int'(vld[k]), 0);
        end
    endtask

    task automatic restart();
        en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_idle("disabled");
        model_reset();
    endtask

    initial begin
        int t;
        int a;
        model_reset();
        #20;
        check_idle("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        restart();
        do_update(100, 40, 1'b1);
        do_update(1000, 0, 1'b0);
        do_update(0, 50, 1'b0);

        restart();
        do_update(10, 0, 1'b1);
        repeat (3) do_update(10, 0, 1'b0);

        restart();
        do_update(200, 0, 1'b1);
        repeat (3) do_update(200, 0, 1'b0);
        repeat (2) do_update(0, 10, 1'b0);

        restart();
        do_update(100, 0, 1'b1);
        do_update(100, 50, 1'b0);
        do_update(100, 0, 1'b0);

        // Abort by enable_in during MUL_I
        restart();
        do_update(300, 100, 1'b1);
        do_update(300, 100, 1'b0);
        tgt = 10'd500;
        act = 10'd0;
        model_step(500, 0);
        repeat (N - LAT + 3) begin
            @(posedge clk);
            #1;
        end
        en = 1'b0;
        model_reset();
        repeat (2 * N) begin
            @(posedge clk);
            #1;
        end
        check_idle("abort_en");
        do_update(150, 100, 1'b1);
        do_update(150, 100, 1'b0);

        // Abort by asynchronous reset during MUL_I
        tgt = 10'd900;
        act = 10'd100;
        model_step(900, 100);
        repeat (N - LAT + 3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #5;
        check_idle("abort_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_update(150, 100, 1'b1);
        do_update(150, 100, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit first;
            first = 1'b0;
            if (i % 13 == 12) begin
                restart();
                first = 1'b1;
            end
            t = int'($urandom_range(0, 1023));
            if (i % 2 == 1) a = int'($urandom_range(0, 1023));
            else a = t + int'($urandom_range(0, 80)) - 40;
            if (a < 0) a = 0;
            if (a > 1023) a = 1023;
            do_update(t, a, first);
        end

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < NI; k++)
            check($sformatf("leftover[%0d]", k), exp_q[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
